// File: rtl/mem_access_unit.sv
// Memory-stage dbus controller: turns one load/store per instruction into a
// valid/addr_ok/data_ok transaction, stalls until data returns, extends loads.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_valid,
  input  logic              ex_write,
  input  logic [2:0]        ex_op,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic              flush,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misalign,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [3:0]        dreq_strobe,
  output logic [31:0]       dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [31:0]       dresp_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              killed_q, killed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        size_q, size_d;
  logic [3:0]        strobe_q, strobe_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        op_q, op_d;
  logic              write_q, write_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        is_byte, is_half, is_word, op_legal, align_fail, in_idle, issue;
  logic [2:0]  req_size;
  logic [3:0]  req_strobe;
  logic [31:0] req_data;
  logic [31:0] shifted, load_ext;

  // Low two op bits select width; bit 2 only means "unsigned" for byte/half.
  assign is_byte    = (ex_op[1:0] == 2'b00);
  assign is_half    = (ex_op[1:0] == 2'b01);
  assign is_word    = (ex_op == 3'b010);
  assign op_legal   = is_byte | is_half | is_word;
  assign align_fail = (is_half & ex_addr[0]) | (is_word & (ex_addr[1:0] != 2'b00));
  assign in_idle    = (state_q == IDLE);

  // Gating with resetn keeps the combinational outputs at 0 while reset is held.
  assign issue    = resetn & in_idle & ex_valid & op_legal & ~align_fail & ~flush;
  assign misalign = resetn & in_idle & ex_valid & align_fail;

  always_comb begin
    req_size   = 3'd0;
    req_strobe = 4'b0000;
    req_data   = 32'd0;
    if (is_word) begin
      req_size = 3'd2;
    end else if (is_half) begin
      req_size = 3'd1;
    end
    if (ex_write) begin
      if (is_word) begin
        req_strobe = 4'b1111;
        req_data   = ex_wdata;
      end else if (is_half) begin
        req_strobe = 4'b0011 << ex_addr[1:0];
        req_data   = {2{ex_wdata[15:0]}};
      end else begin
        req_strobe = 4'b0001 << ex_addr[1:0];
        req_data   = {4{ex_wdata[7:0]}};
      end
    end
  end

  assign shifted = dresp_data >> {off_q, 3'b000};

  always_comb begin
    case (op_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = dresp_data;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    killed_d = killed_q;
    addr_d   = addr_q;
    size_d   = size_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    op_d     = op_q;
    write_d  = write_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        killed_d = 1'b0;
        if (issue) begin
          addr_d   = ex_addr;
          size_d   = req_size;
          strobe_d = req_strobe;
          data_d   = req_data;
          op_d     = ex_op;
          write_d  = ex_write;
          off_d    = ex_addr[1:0];
          state_d  = REQ;
        end
      end
      REQ: begin
        // A flushed op still completes on the bus; only its result is dropped.
        if (flush) killed_d = 1'b1;
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            rdata_d = load_ext;
            state_d = DONE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (flush) killed_d = 1'b1;
        if (dresp_data_ok) begin
          rdata_d = load_ext;
          state_d = DONE;
        end
      end
      DONE: begin
        killed_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      killed_q <= 1'b0;
      addr_q   <= '0;
      size_q   <= 3'd0;
      strobe_q <= 4'd0;
      data_q   <= 32'd0;
      op_q     <= 3'd0;
      write_q  <= 1'b0;
      off_q    <= 2'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      op_q     <= op_d;
      write_q  <= write_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
    end
  end

  assign stall       = issue | (state_q == REQ) | (state_q == WAIT);
  assign dreq_valid  = (state_q == REQ);
  assign dreq_addr   = addr_q;
  assign dreq_size   = size_q;
  assign dreq_strobe = strobe_q;
  assign dreq_data   = data_q;
  assign rdata       = rdata_q;
  assign rdata_valid = (state_q == DONE) & ~write_q & ~killed_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random loads/stores against a
// transaction-level model of the dbus encoding, stall timing and load extension.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid, ex_write, flush;
  logic [2:0]  ex_op;
  logic [31:0] ex_addr, ex_wdata;
  logic        stall, rdata_valid, misalign, dreq_valid;
  logic [31:0] rdata, dreq_addr, dreq_data;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .ex_valid(ex_valid), .ex_write(ex_write), .ex_op(ex_op),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .flush(flush),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .misalign(misalign),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic int width_of(input logic [2:0] op);
    if (op == 3'b010) return 4;
    if (op == 3'b001 || op == 3'b101) return 2;
    if (op == 3'b000 || op == 3'b100) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] d);
    logic [31:0] v;
    v = d;
    if (width_of(op) == 1) begin
      v = (d >> (8 * off)) % 256;
      if (op == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (width_of(op) == 2) begin
      v = (d >> (8 * off)) % 65536;
      if (op == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // flush_cyc: -1 none, 0 in the issue cycle, k>=1 in the k-th cycle after issue.
  task automatic run_op(input bit wr, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input int da, input int dd,
                        input int flush_cyc, input logic [31:0] resp);
    int w, busy;
    bit aligned, exp_issue, killed;
    logic [31:0] exp_strobe, exp_data, exp_size;
    w         = width_of(op);
    aligned   = (w == 0) || ((addr % w) == 0);
    exp_issue = (w != 0) && aligned && (flush_cyc != 0);
    busy      = da + 1 + dd;
    killed    = (flush_cyc >= 1) && (flush_cyc <= busy);
    exp_size  = (w == 4) ? 2 : (w == 2) ? 1 : 0;
    exp_strobe = 0;
    exp_data   = 0;
    if (wr) begin
      exp_strobe = ((1 << w) - 1) << (addr % 4);
      exp_data   = (w == 4) ? wd : (w == 2) ? (wd % 65536) * 32'h0001_0001
                                            : (wd % 256) * 32'h0101_0101;
    end

    @(posedge clk); #1;
    ex_valid = 1'b1; ex_write = wr; ex_op = op; ex_addr = addr; ex_wdata = wd;
    flush = (flush_cyc == 0);
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = $urandom;
    @(negedge clk);
    check("issue_stall", 32'(stall), 32'(exp_issue));
    check("issue_misalign", 32'(misalign), 32'((w != 0) && !aligned));
    check("issue_dreq_valid", 32'(dreq_valid), 0);

    if (!exp_issue) begin
      @(posedge clk); #1;
      ex_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("noissue_dreq_valid", 32'(dreq_valid), 0);
      check("noissue_stall", 32'(stall), 0);
      check("noissue_rdata_valid", 32'(rdata_valid), 0);
      $display("op wr=%0d op=%0d addr=%08h no-issue", wr, op, addr);
      return;
    end

    for (int k = 1; k <= busy; k++) begin
      @(posedge clk); #1;
      flush         = (k == flush_cyc);
      dresp_addr_ok = (k == da + 1);
      dresp_data_ok = (k == busy);
      dresp_data    = (k == busy) ? resp : $urandom;
      @(negedge clk);
      check("busy_stall", 32'(stall), 1);
      check("busy_rdata_valid", 32'(rdata_valid), 0);
      if (k <= da + 1) begin
        check("req_valid", 32'(dreq_valid), 1);
        check("req_addr", dreq_addr, addr);
        check("req_size", 32'(dreq_size), exp_size);
        check("req_strobe", 32'(dreq_strobe), exp_strobe);
        check("req_data", dreq_data, exp_data);
      end else begin
        check("wait_valid", 32'(dreq_valid), 0);
      end
    end
    last_rdata = model_load(op, addr[1:0], resp);

    @(posedge clk); #1;
    flush = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = $urandom;
    @(negedge clk);
    check("done_stall", 32'(stall), 0);
    check("done_dreq_valid", 32'(dreq_valid), 0);
    check("done_rdata_valid", 32'(rdata_valid), 32'(!wr && !killed));
    check("done_rdata", rdata, last_rdata);

    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    check("after_rdata_valid", 32'(rdata_valid), 0);
    check("after_stall", 32'(stall), 0);
    check("after_dreq_valid", 32'(dreq_valid), 0);
    check("after_rdata_hold", rdata, last_rdata);
    $display("op wr=%0d op=%0d addr=%08h da=%0d dd=%0d flush=%0d rdata=%08h",
             wr, op, addr, da, dd, flush_cyc, rdata);
  endtask

  initial begin
    logic [2:0] rop;
    int rda, rdd, rfl;
    resetn = 1'b0; ex_valid = 1'b0; ex_write = 1'b0; ex_op = 3'd0;
    ex_addr = 32'd0; ex_wdata = 32'd0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'd0;
    last_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1; resetn = 1'b1;
    @(negedge clk);
    check("rst_stall", 32'(stall), 0);
    check("rst_dreq_valid", 32'(dreq_valid), 0);
    check("rst_rdata_valid", 32'(rdata_valid), 0);
    check("rst_rdata", rdata, 0);
    check("rst_dreq_addr", dreq_addr, 0);
    check("rst_dreq_strobe", 32'(dreq_strobe), 0);
    $display("reset done");

    run_op(0, 3'b010, 32'h8000_0010, 0, 0, 0, -1, 32'hDEAD_BEEF);
    run_op(0, 3'b000, 32'h8000_0013, 0, 0, 0, -1, 32'h80FF_FFFF);
    run_op(0, 3'b100, 32'h8000_0013, 0, 1, 0, -1, 32'h80FF_FFFF);
    run_op(0, 3'b001, 32'h8000_0002, 0, 0, 1, -1, 32'h8001_0000);
    run_op(1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 0, 0, -1, 32'h0);
    run_op(1, 3'b001, 32'h8000_0002, 32'h1234_56AB, 0, 0, -1, 32'h0);
    run_op(0, 3'b010, 32'h8000_0020, 0, 3, 2, -1, 32'h0BAD_F00D);
    run_op(0, 3'b010, 32'h8000_0002, 0, 0, 0, -1, 32'h0);
    run_op(1, 3'b001, 32'h8000_0001, 32'h1, 0, 0, -1, 32'h0);
    run_op(0, 3'b011, 32'h8000_0000, 0, 0, 0, -1, 32'h0);
    run_op(0, 3'b010, 32'h8000_0040, 0, 0, 2, 2, 32'h1357_9BDF);
    run_op(1, 3'b010, 32'h8000_0044, 32'hCAFE_0001, 1, 1, 1, 32'h0);

    // data_ok while idle must not disturb anything
    @(posedge clk); #1;
    dresp_data_ok = 1'b1; dresp_data = 32'hA5A5_5A5A;
    @(negedge clk);
    check("idle_dok_stall", 32'(stall), 0);
    check("idle_dok_rvalid", 32'(rdata_valid), 0);
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    @(negedge clk);
    check("idle_dok_rdata", rdata, last_rdata);
    check("idle_dok_dreq_valid", 32'(dreq_valid), 0);

    // reset in REQ abandons the transaction
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_write = 1'b0; ex_op = 3'b010; ex_addr = 32'h8000_0080;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    check("rstreq_in_req", 32'(dreq_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstreq_dreq_valid", 32'(dreq_valid), 0);
    check("rstreq_stall", 32'(stall), 0);
    check("rstreq_rdata", rdata, 0);
    last_rdata = 32'd0;
    resetn = 1'b1; ex_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstreq_idle_valid", 32'(dreq_valid), 0);
    check("rstreq_idle_stall", 32'(stall), 0);
    $display("reset during REQ done");

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    rop = 3'b010;
        2:       rop = 3'b000;
        3:       rop = 3'b100;
        4:       rop = 3'b001;
        5:       rop = 3'b101;
        6:       rop = 3'b011 + 3'($urandom_range(0, 1)) * 3'b100;
        default: rop = 3'($urandom_range(0, 5) == 0 ? 6 : 2);
      endcase
      rda = $urandom_range(0, 3);
      rdd = $urandom_range(0, 3);
      rfl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rda + 1 + rdd) : -1;
      run_op(1'($urandom_range(0, 1)), rop, $urandom, $urandom, rda, rdd, rfl, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
